// File: rtl/psg_env_ctrl.sv
// PSG attribute-write front end: sample strobe, per-channel linear volume envelope, CPU-priority arbitration.
// Build with PSG_ENV_IRQ_EN defined to get the sticky envelope-complete interrupt (env_irq).
module psg_env_ctrl #(
  parameter int SAMPLE_DIV = 512,
  parameter int ENV_DIV    = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] cpu_addr,
  input  logic [7:0] cpu_wrdata,
  input  logic       cpu_write,
  input  logic [3:0] env_addr,
  input  logic [7:0] env_wrdata,
  input  logic       env_write,
  output logic [5:0] attr_addr,
  output logic [7:0] attr_wrdata,
  output logic       attr_write,
  output logic       next_sample,
  output logic       env_busy,
  output logic       env_irq,
  input  logic       env_irq_ack
);

  localparam int SW = $clog2(SAMPLE_DIV);
  localparam int EW = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, WRITE} state_t;

  state_t        state_q;
  logic [3:0]    ch_q;
  logic [5:0]    new_vol_q;
  logic [SW-1:0] smp_cnt_q;
  logic [EW-1:0] tick_cnt_q;

  logic [5:0]    cur_vol_q [16];
  logic [5:0]    tgt_vol_q [16];
  logic [1:0]    lr_q      [16];
  logic [15:0]   en_q;

  logic          smp_wrap;
  logic          env_tick;
  logic [3:0]    cpu_ch;
  logic          cpu_b2;
  logic          env_grant;
  logic          env_cancel;
  logic [5:0]    cur_sel;
  logic [5:0]    tgt_sel;
  logic [5:0]    new_vol_d;

  assign smp_wrap    = (smp_cnt_q == SW'(SAMPLE_DIV - 1));
  assign env_tick    = smp_wrap && (tick_cnt_q == EW'(ENV_DIV - 1));
  assign next_sample = smp_wrap;
  assign env_busy    = (state_q != IDLE);

  assign cpu_ch     = cpu_addr[5:2];
  assign cpu_b2     = cpu_write && (cpu_addr[1:0] == 2'b10);
  assign env_grant  = (state_q == WRITE) && !cpu_write;
  // A CPU byte-2 write to the channel being stepped supersedes the envelope step.
  assign env_cancel = (state_q == WRITE) && cpu_b2 && (cpu_ch == ch_q);

  assign cur_sel   = cur_vol_q[ch_q];
  assign tgt_sel   = tgt_vol_q[ch_q];
  assign new_vol_d = (cur_sel < tgt_sel) ? cur_sel + 6'd1 : cur_sel - 6'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_cnt_q  <= '0;
      tick_cnt_q <= '0;
    end else begin
      smp_cnt_q <= smp_wrap ? '0 : smp_cnt_q + SW'(1);
      if (smp_wrap) begin
        tick_cnt_q <= env_tick ? '0 : tick_cnt_q + EW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        cur_vol_q[i] <= '0;
        tgt_vol_q[i] <= '0;
        lr_q[i]      <= '0;
      end
      en_q <= '0;
    end else begin
      if (cpu_b2) begin
        lr_q[cpu_ch]      <= cpu_wrdata[7:6];
        cur_vol_q[cpu_ch] <= cpu_wrdata[5:0];
      end else if (env_grant) begin
        cur_vol_q[ch_q] <= new_vol_q;
      end
      if (env_write) begin
        en_q[env_addr]      <= env_wrdata[7];
        tgt_vol_q[env_addr] <= env_wrdata[5:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      new_vol_q   <= '0;
      attr_write  <= 1'b0;
      attr_addr   <= '0;
      attr_wrdata <= '0;
    end else begin
      attr_write <= 1'b0;
      if (cpu_write) begin
        attr_write  <= 1'b1;
        attr_addr   <= cpu_addr;
        attr_wrdata <= cpu_wrdata;
      end else if (state_q == WRITE) begin
        attr_write  <= 1'b1;
        attr_addr   <= {ch_q, 2'b10};
        attr_wrdata <= {lr_q[ch_q], new_vol_q};
      end

      case (state_q)
        IDLE: begin
          if (env_tick) begin
            state_q <= SCAN;
            ch_q    <= '0;
          end
        end
        SCAN: begin
          if (en_q[ch_q] && (cur_sel != tgt_sel)) begin
            new_vol_q <= new_vol_d;
            state_q   <= WRITE;
          end else if (ch_q == 4'd15) begin
            state_q <= IDLE;
          end else begin
            ch_q <= ch_q + 4'd1;
          end
        end
        WRITE: begin
          if (env_grant || env_cancel) begin
            if (ch_q == 4'd15) begin
              state_q <= IDLE;
            end else begin
              ch_q    <= ch_q + 4'd1;
              state_q <= SCAN;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PSG_ENV_IRQ_EN
  logic irq_q;
  logic unused_res;
  assign unused_res = env_wrdata[6];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else if (env_grant && en_q[ch_q] && (new_vol_q == tgt_sel)) begin
      irq_q <= 1'b1;
    end else if (env_irq_ack) begin
      irq_q <= 1'b0;
    end
  end

  assign env_irq = irq_q;
`else
  logic unused_res;
  assign unused_res = env_wrdata[6] ^ env_irq_ack;
  assign env_irq    = 1'b0;
`endif

endmodule
